// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester and FIFO write-port signals of fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 41,
    parameter int NUM_REQ    = 2,
    parameter int CNT_WIDTH  = 16
);
    localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          full;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic [IDW-1:0]                grant_id;
    logic                          busy;
    logic [CNT_WIDTH-1:0]          wr_count;

    modport slave (
        input  req_valid, req_last, req_data, full,
        output req_ready, wr_en, wr_data, grant_id, busy, wr_count
    );

    modport master (
        output req_valid, req_last, req_data, full,
        input  req_ready, wr_en, wr_data, grant_id, busy, wr_count
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin FIFO write-port arbiter with packet lock and one-entry output register
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 41,
    parameter int NUM_REQ    = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic             wr_clk,
    input  logic             wr_rst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state, state_nxt;
    logic [IDW-1:0]        ptr, ptr_nxt, owner, owner_nxt;
    logic [IDW-1:0]        rr_pick, gnt, grant_id;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data, sel_data;
    logic [CNT_WIDTH-1:0]  wr_count;
    logic [NUM_REQ-1:0]    ready;
    logic                  wr_en, accept, found, offer, xfer, xfer_last;

    assign wr_en  = out_valid & ~bus.full;
    // The slot can take a beat when empty or when its beat leaves this cycle.
    assign accept = ~out_valid | wr_en;

    always_comb begin
        logic [IDW-1:0] idx;
        found   = 1'b0;
        rr_pick = ptr;
        idx     = '0;
        // Walk downward so the closest valid requester at or after ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                found   = 1'b1;
                rr_pick = idx;
            end
        end
    end

    always_comb begin
        gnt       = (state == LOCKED) ? owner : rr_pick;
        offer     = accept & ~wr_rst & ((state == LOCKED) | found);
        ready     = '0;
        xfer_last = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt == IDW'(i)) begin
                ready[i]  = offer;
                xfer_last = bus.req_last[i];
                sel_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        xfer = |(ready & bus.req_valid);
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        if (xfer) begin
            if (xfer_last) begin
                state_nxt = IDLE;
                ptr_nxt   = (gnt == IDW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
            end else begin
                state_nxt = LOCKED;
                owner_nxt = gnt;
            end
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            grant_id  <= '0;
            wr_count  <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                grant_id  <= gnt;
            end else if (wr_en) begin
                out_valid <= 1'b0;
            end
            if (wr_en) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.wr_en     = wr_en;
    assign bus.wr_data   = out_data;
    assign bus.grant_id  = grant_id;
    assign bus.busy      = (state == LOCKED);
    assign bus.wr_count  = wr_count;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int DW = 16;
    localparam int NR = 2;
    localparam int CW = 4;

    logic wr_clk = 1'b0;
    logic wr_rst;
    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(CW)) bus ();

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
        .wr_clk (wr_clk),
        .wr_rst (wr_rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW:0]   rq [NR][$];
    logic [DW-1:0] exp_q [$];
    logic [NR-1:0] hs = '0;
    logic          full_drv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge wr_clk);
        #3;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || rq[0].size() != 0 || rq[1].size() != 0) && n < budget) begin
            step(1);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Requester driver: retire handshaken beats and present the next head at each falling edge.
    initial begin
        logic [DW:0] b;
        forever begin
            @(negedge wr_clk);
            for (int i = 0; i < NR; i++)
                if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            bus.full = full_drv;
            for (int i = 0; i < NR; i++) begin
                if (rq[i].size() > 0) begin
                    b = rq[i][0];
                    bus.req_valid[i] = 1'b1;
                    bus.req_last[i]  = b[DW];
                    bus.req_data[i*DW +: DW] = b[DW-1:0];
                end else begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_last[i]  = 1'b0;
                    bus.req_data[i*DW +: DW] = '0;
                end
            end
            #1;
            hs = bus.req_valid & bus.req_ready;
        end
    end

    // Monitor: every FIFO write must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge wr_clk);
            #2;
            if (!wr_rst && bus.wr_en) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wr_unexpected: actual %0h required no write", bus.wr_data);
                end else begin
                    check("wr_data_order", bus.wr_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        wr_rst        = 1'b1;
        bus.full      = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;

        step(2);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_wr_count", bus.wr_count, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_wr_data", bus.wr_data, 0);
        wr_rst = 1'b0;

        // Round-robin: single-beat packets from both requesters alternate.
        for (int i = 0; i < 4; i++) begin
            rq[0].push_back({1'b1, 16'hA000 + 16'(i)});
            rq[1].push_back({1'b1, 16'hB000 + 16'(i)});
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(16'hA000 + 16'(i));
            exp_q.push_back(16'hB000 + 16'(i));
        end
        step(10);
        check("rr_wr_count", bus.wr_count, 8);
        check("rr_grant_id", bus.grant_id, 1);
        drain(20);

        // Atomic packet from requester 0 while requester 1 is always valid.
        for (int i = 0; i < 4; i++) rq[0].push_back({(i == 3) ? 1'b1 : 1'b0, 16'hC000 + 16'(i)});
        rq[1].push_back({1'b1, 16'hD000});
        rq[1].push_back({1'b1, 16'hD001});
        for (int i = 0; i < 4; i++) exp_q.push_back(16'hC000 + 16'(i));
        exp_q.push_back(16'hD000);
        exp_q.push_back(16'hD001);
        step(2);
        check("lock_busy", bus.busy, 1);
        check("lock_ready", bus.req_ready, 2'b01);
        step(3);
        check("unlock_busy", bus.busy, 0);
        check("unlock_ready", bus.req_ready, 2'b10);
        drain(20);
        step(1);
        check("pkt_wr_count", bus.wr_count, 14);

        // Backpressure: one beat loads under full, then holds until full clears.
        full_drv = 1'b1;
        rq[0].push_back({1'b1, 16'hE000});
        rq[0].push_back({1'b1, 16'hE001});
        rq[1].push_back({1'b1, 16'hF000});
        exp_q.push_back(16'hE000);
        exp_q.push_back(16'hF000);
        exp_q.push_back(16'hE001);
        step(2);
        for (int i = 0; i < 5; i++) begin
            check("full_wr_en", bus.wr_en, 0);
            check("full_ready", bus.req_ready, 0);
            check("full_wr_data", bus.wr_data, 16'hE000);
            step(1);
        end
        full_drv = 1'b0;
        step(1);
        check("release_wr_en", bus.wr_en, 1);
        check("release_wr_data", bus.wr_data, 16'hE000);
        check("release_ready", bus.req_ready, 2'b10);
        drain(20);
        step(1);
        check("wrap_wr_count", bus.wr_count, 1);

        // Reset in the middle of a 4-beat packet discards the rest and frees the lock.
        for (int i = 0; i < 4; i++) rq[0].push_back({(i == 3) ? 1'b1 : 1'b0, 16'h6000 + 16'(i)});
        exp_q.push_back(16'h6000);
        exp_q.push_back(16'h6001);
        step(3);
        check("mid_busy", bus.busy, 1);
        check("mid_pending", exp_q.size(), 0);
        wr_rst = 1'b1;
        rq[0].delete();
        #1;
        check("arst_wr_en", bus.wr_en, 0);
        check("arst_req_ready", bus.req_ready, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_wr_count", bus.wr_count, 0);
        check("arst_grant_id", bus.grant_id, 0);
        step(1);
        wr_rst = 1'b0;
        rq[1].push_back({1'b1, 16'h7000});
        exp_q.push_back(16'h7000);
        drain(20);
        step(1);
        check("post_rst_count", bus.wr_count, 1);
        check("post_rst_grant", bus.grant_id, 1);
        check("post_rst_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter and write sequencer for the write port of the bridge's asynchronous FIFO. It shares the single FIFO write port (`wr_en`/`wr_data`/`full`) between NUM_REQ requesters, for example the AHB write-data path and the command/config path. Multi-beat packets are kept atomic via `req_last`. A one-entry output register decouples requester handshakes from FIFO backpressure.

## Interface
- `DATA_WIDTH`, default 41: width of one FIFO entry.
- `NUM_REQ`, default 2: number of requesters, legal range 2..8.
- `CNT_WIDTH`, default 16: width of the write counter.
- `IDW` (localparam) = max(1, $clog2(NUM_REQ)).

Ports:
- `wr_clk`  in  1  write-domain clock; all logic on its rising edge.
- `wr_rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_last`  in  NUM_REQ  per-requester last beat of packet; qualified by `req_valid`.
- `req_data`  in  NUM_REQ*DATA_WIDTH  flattened; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  per-requester accept, combinational; at most one bit high.
- `full`  in  1  FIFO full flag, synchronous to `wr_clk`.
- `wr_en`  out  1  FIFO write strobe.
- `wr_data`  out  DATA_WIDTH  FIFO write data.
- `grant_id`  out  IDW  requester owning the most recently loaded beat.
- `busy`  out  1  high while a multi-beat packet holds the lock.
- `wr_count`  out  CNT_WIDTH  number of FIFO writes issued; wraps.

## Operation
- **Output stage**
  - Registers `out_valid` and `out_data`.
  - `wr_en = out_valid & ~full` (combinational). `wr_data = out_data`.
  - `accept = ~out_valid | wr_en`: the slot is free, or it is draining this cycle.
- **Transfer**: requester i transfers a beat when `req_valid[i] & req_ready[i]`. On a transfer:
  - `out_data <= req_data[i]`, `out_valid <= 1`, `grant_id <= i`.
  - If there is no transfer and `wr_en` is high, `out_valid <= 0`.
- **State IDLE**
  - If `accept` is high, grant the first requester with `req_valid` set, searching from `ptr` upward modulo NUM_REQ. Assert `req_ready` for that requester only.
  - Transfer with `req_last=1`: stay IDLE, `ptr <= (i+1) mod NUM_REQ`.
  - Transfer with `req_last=0`: go to LOCKED, `owner <= i`.
- **State LOCKED**
  - `req_ready[owner] = accept`; all other `req_ready` bits are 0.
  - Owner transfer with `req_last=1`: go to IDLE, `ptr <= (owner+1) mod NUM_REQ`.
  - Owner deasserting `req_valid` mid-packet does not release the lock.
- **Outputs**
  - `busy = (state == LOCKED)`.
  - `wr_count` increments by 1 on every cycle with `wr_en=1`, wrapping modulo 2^CNT_WIDTH.
- **Boundary conditions**
  - `full` high with `out_valid=1`: `wr_en=0`, the beat is held, all `req_ready=0`.
  - `full` falling: the held beat is written that cycle. A new beat may load in the same cycle, so `out_valid` stays 1.
  - `full` high with `out_valid=0`: one beat may still load. It then holds until `full` clears.
  - No requester valid: no transfer; `ptr` and state are unchanged.
  - `ptr` wraps from NUM_REQ-1 to 0.
- **Reset** (asynchronous, any time including mid-packet)
  - State IDLE, `ptr=0`, `owner=0`, `out_valid=0`, `out_data=0`.
  - Outputs: `wr_en=0`, `wr_data=0`, `grant_id=0`, `busy=0`, `wr_count=0`.
  - `req_ready` is forced to 0 while `wr_rst` is high.
  - The in-flight beat and partial packet are discarded. Requesters must restart the packet.

## Timing
- **Latency**: a beat accepted at edge N appears on `wr_en`/`wr_data` in the cycle after edge N, provided `full=0`.
- **Throughput**: one beat per cycle sustained while `full=0`, including back-to-back packets from different requesters.
- **Combinational paths**:
  - `req_ready` depends on `req_valid`, `full`, state and `ptr`.
  - Requesters must not derive `req_valid` from `req_ready`.
  - `req_data`/`req_last` must be held stable while `req_valid` is high and `req_ready` is low.
- **Arbitration**:
  - The decision is made in the handshake cycle.
  - The `ptr` update takes effect on the next decision.
  - A packet is never interleaved with another requester's beats.

## Test plan
- **Reset**: assert `wr_rst` asynchronously mid-cycle -> immediately `wr_en=0`, `req_ready=0`, `busy=0`, `wr_count=0`, `grant_id=0`.
- **Round-robin fairness**: NUM_REQ=2, both requesters valid with single-beat packets (`last=1`), data 0xA00..., 0xB00... -> FIFO order alternates 0, 1, 0, 1. `wr_count` reaches 8 after 8 writes with one write per cycle.
- **Packet atomicity**:
  - Requester 0 sends a 4-beat packet (`last` on beat 4) while requester 1 is continuously valid.
  - Required: all 4 beats from requester 0 are written consecutively, `busy=1` for beats 1-3, then requester 1 is granted.
- **Backpressure**:
  - Hold `full=1` for 5 cycles with a beat loaded -> `wr_en=0`, `wr_data` stable, `req_ready=0`.
  - `full` drops -> the held beat is written and a new beat loads in the same cycle.
- **Mid-packet reset**: reset after beat 2 of a 4-beat packet -> lock released. After reset, requester 1 is granted first if it is the only valid requester.
- **Counter wrap**: CNT_WIDTH=4, 17 writes -> `wr_count` reads 1.
